// File: rtl/tp_audio_pkg.sv
// rtl/tp_audio_pkg.sv - shared audio constants, sample type and saturation helper
package tp_audio_pkg;

  localparam int SAMPLE_W        = 16;
  localparam int DIV_DEFAULT     = 1024;
  localparam int K_SHIFT_DEFAULT = 2;
  localparam int GUARD_DEFAULT   = 8;
  localparam int SAT_IN_W        = 32;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  function automatic sample_t sat16(input logic signed [SAT_IN_W-1:0] v);
    if (v > 32'sd32767)
      return 16'sh7fff;
    else if (v < -32'sd32768)
      return 16'sh8000;
    else
      return v[SAMPLE_W-1:0];
  endfunction

endpackage

// File: rtl/tp_iir_stage.sv
// rtl/tp_iir_stage.sv - one first-order IIR low-pass stage, acc += (x - acc) >>> K_SHIFT
module tp_iir_stage #(
  parameter int K_SHIFT = 2,
  parameter int W       = 25
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic signed [W-1:0] x,
  output logic signed [W-1:0] acc
);

  logic signed [W:0] diff;
  logic signed [W:0] step;
  logic signed [W:0] sum;

  // One extra bit keeps the difference exact for any pair of W-bit operands.
  assign diff = {x[W-1], x} - {acc[W-1], acc};
  assign step = diff >>> K_SHIFT;
  assign sum  = {acc[W-1], acc} + step;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      acc <= '0;
    else if (en)
      acc <= sum[W-1:0];
  end

endmodule

// File: rtl/tp_sound_filter.sv
// rtl/tp_sound_filter.sv - decimating two-stage RC-emulation low-pass for the core audio output
module tp_sound_filter
  import tp_audio_pkg::*;
#(
  parameter int DIV     = DIV_DEFAULT,
  parameter int K_SHIFT = K_SHIFT_DEFAULT,
  parameter int GUARD   = GUARD_DEFAULT
) (
  input  logic                       clk_49m,
  input  logic                       reset_n,
  input  logic signed [SAMPLE_W-1:0] sound_in,
  input  logic                       filt_en,
  input  logic                       mute,
  output logic signed [SAMPLE_W-1:0] sound_out,
  output logic                       sample_stb
);

  localparam int ACC_W = SAMPLE_W + GUARD + 1;
  localparam int CNT_W = $clog2(DIV);

  logic [CNT_W-1:0]            count;
  logic                        tick;
  sample_t                     x_q;
  logic                        fe_q;
  logic                        mu_q;
  logic                        v0;
  logic                        v1;
  logic signed [ACC_W-1:0]     x_ext;
  logic signed [ACC_W-1:0]     acc1;
  logic signed [ACC_W-1:0]     acc2;
  logic signed [SAT_IN_W-1:0]  res_wide;

  assign tick = (count == CNT_W'(DIV - 1));

  always_ff @(posedge clk_49m or negedge reset_n) begin
    if (!reset_n)
      count <= '0;
    else if (tick)
      count <= '0;
    else
      count <= count + CNT_W'(1);
  end

  // Controls and the raw sample are captured once per output period.
  always_ff @(posedge clk_49m or negedge reset_n) begin
    if (!reset_n) begin
      x_q  <= '0;
      fe_q <= 1'b0;
      mu_q <= 1'b0;
      v0   <= 1'b0;
      v1   <= 1'b0;
    end else begin
      v0 <= tick;
      v1 <= v0;
      if (tick) begin
        x_q  <= sound_in;
        fe_q <= filt_en;
        mu_q <= mute;
      end
    end
  end

  // Stage 1 consumes the same edge-sampled value that x_q captures.
  assign x_ext = {sound_in[SAMPLE_W-1], sound_in, {GUARD{1'b0}}};

  tp_iir_stage #(.K_SHIFT(K_SHIFT), .W(ACC_W)) u_stage1 (
    .clk   (clk_49m),
    .rst_n (reset_n),
    .en    (tick),
    .x     (x_ext),
    .acc   (acc1)
  );

  tp_iir_stage #(.K_SHIFT(K_SHIFT), .W(ACC_W)) u_stage2 (
    .clk   (clk_49m),
    .rst_n (reset_n),
    .en    (v0),
    .x     (acc1),
    .acc   (acc2)
  );

  always_comb begin
    res_wide = '0;
    if (!mu_q) begin
      if (fe_q)
        res_wide = SAT_IN_W'(acc2 >>> GUARD);
      else
        res_wide = SAT_IN_W'(x_q);
    end
  end

  always_ff @(posedge clk_49m or negedge reset_n) begin
    if (!reset_n) begin
      sound_out  <= '0;
      sample_stb <= 1'b0;
    end else begin
      sample_stb <= v1;
      if (v1)
        sound_out <= sat16(res_wide);
    end
  end

endmodule

// File: tb/tb_tp_sound_filter.sv
// tb/tb_tp_sound_filter.sv - directed self-checking bench for tp_sound_filter
module tb_tp_sound_filter;

  localparam int DIV = 64;
  localparam int KS  = 2;
  localparam int G   = 8;

  logic               clk_49m = 1'b0;
  logic               reset_n = 1'b0;
  logic signed [15:0] sound_in = '0;
  logic               filt_en = 1'b0;
  logic               mute = 1'b0;
  logic signed [15:0] sound_out;
  logic               sample_stb;

  int n_tests = 0;
  int n_fail  = 0;
  longint m1 = 0;
  longint m2 = 0;

  tp_sound_filter #(.DIV(DIV), .K_SHIFT(KS), .GUARD(G)) dut (
    .clk_49m    (clk_49m),
    .reset_n    (reset_n),
    .sound_in   (sound_in),
    .filt_en    (filt_en),
    .mute       (mute),
    .sound_out  (sound_out),
    .sample_stb (sample_stb)
  );

  always #5 clk_49m = ~clk_49m;

  task automatic check(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_stb(output int n);
    n = 0;
    do begin
      @(negedge clk_49m);
      n++;
    end while (!sample_stb && n < 4 * DIV);
    if (!sample_stb)
      check("stb_timeout", n, -1);
  endtask

  function automatic longint model(input longint x, input bit fe, input bit mu);
    longint r;
    m1 = m1 + (((x <<< G) - m1) >>> KS);
    m2 = m2 + ((m1 - m2) >>> KS);
    r  = mu ? 0 : (fe ? (m2 >>> G) : x);
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    return r;
  endfunction

  task automatic sample(input int x, input bit fe, input bit mu,
                        output longint got, output longint exp);
    int n;
    sound_in = 16'(x);
    filt_en  = fe;
    mute     = mu;
    wait_stb(n);
    got = longint'(sound_out);
    exp = model(longint'(x), fe, mu);
  endtask

  initial begin
    int n;
    longint got, exp, prev;
    int errs;
    bit mono, over, seen;

    // Reset state and strobe timing
    repeat (3) @(negedge clk_49m);
    check("rst_sound_out", longint'(sound_out), 0);
    check("rst_stb", longint'(sample_stb), 0);
    reset_n = 1'b1;
    wait_stb(n);
    check("first_stb_delay", n, DIV + 2);
    wait_stb(n);
    check("stb_spacing", n, DIV);
    @(negedge clk_49m);
    check("stb_width", longint'(sample_stb), 0);
    wait_stb(n);
    check("stb_spacing_after_width", n, DIV - 1);

    // Step response from a clean state
    reset_n = 1'b0;
    m1 = 0; m2 = 0;
    repeat (2) @(negedge clk_49m);
    reset_n = 1'b1;
    sample(8192, 1, 0, got, exp);
    check("step_1", got, 512);
    sample(8192, 1, 0, got, exp);
    check("step_2", got, 1280);
    sample(8192, 1, 0, got, exp);
    check("step_3", got, 2144);
    prev = got; mono = 1; over = 0; errs = 0;
    for (int i = 3; i < 200; i++) begin
      sample(8192, 1, 0, got, exp);
      if (got < prev) mono = 0;
      if (got > 8192) over = 1;
      if (got != exp) errs++;
      prev = got;
    end
    check("step_monotonic", mono, 1);
    check("step_overshoot", over, 0);
    check("step_model", errs, 0);
    check("step_settled", (got >= 8191 && got <= 8192) ? 1 : 0, 1);

    // Bypass, mute, and resume from running accumulators
    sample(-1234, 0, 0, got, exp);
    check("bypass", got, -1234);
    sample(-1234, 0, 1, got, exp);
    check("mute", got, 0);
    sample(-1234, 1, 0, got, exp);
    check("resume_model", got, exp);
    check("resume_nonzero", (got != 0) ? 1 : 0, 1);

    // filt_en pulsed between ticks must not be seen
    repeat (10) @(negedge clk_49m);
    filt_en = 1'b0;
    repeat (10) @(negedge clk_49m);
    filt_en = 1'b1;
    wait_stb(n);
    exp = model(-1234, 1, 0);
    check("ctl_glitch_ignored", longint'(sound_out), exp);
    // drop filt_en in the cycle right after the tick: applies one sample later
    repeat (DIV - 2) @(negedge clk_49m);
    filt_en = 1'b0;
    wait_stb(n);
    exp = model(-1234, 1, 0);
    check("ctl_late_still_filtered", longint'(sound_out), exp);
    wait_stb(n);
    exp = model(-1234, 0, 0);
    check("ctl_next_bypass", longint'(sound_out), -1234);

    // Full-scale swing
    errs = 0;
    for (int i = 0; i < 200; i++) begin
      sample(32767, 1, 0, got, exp);
      if (got != exp) errs++;
    end
    check("fs_high_settled", (got >= 32766) ? 1 : 0, 1);
    prev = got; mono = 1;
    for (int i = 0; i < 200; i++) begin
      sample(-32768, 1, 0, got, exp);
      if (got > prev) mono = 0;
      if (got != exp) errs++;
      prev = got;
    end
    check("fs_monotonic_down", mono, 1);
    check("fs_model", errs, 0);
    check("fs_low_reached", (got <= -32767) ? 1 : 0, 1);

    // Reset asserted in the cycle after a tick
    sound_in = 16'sd1000;
    filt_en  = 1'b0;
    mute     = 1'b0;
    repeat (DIV - 2) @(negedge clk_49m);
    reset_n = 1'b0;
    #1;
    check("rst_async_out", longint'(sound_out), 0);
    seen = 0;
    repeat (4) begin
      @(negedge clk_49m);
      if (sample_stb) seen = 1;
    end
    check("rst_no_stb", seen, 0);
    m1 = 0; m2 = 0;
    reset_n = 1'b1;
    wait_stb(n);
    check("rst_restart_delay", n, DIV + 2);
    check("rst_restart_value", longint'(sound_out), 1000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
